// File: rtl/wsg_sequencer.sv
// wsg_sequencer: CPU-loaded command FIFO that replays timed writes
// into the wsg register window, paced by an external tick.
module wsg_sequencer #(
  parameter logic [29:0] P_WSG_BASE = 30'h3F008000,
  parameter int          P_DEPTH    = 8
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_SlaveSel,
  input  logic        i_AV_Write,
  input  logic        i_AV_Read,
  input  logic [1:0]  i_Address,
  input  logic [31:0] i_AV_WriteData,
  output logic [31:0] o_AV_ReadData,
  input  logic        i_Tick,
  output logic        o_M_SlaveSel,
  output logic        o_M_Write,
  output logic [29:0] o_M_Address,
  output logic [3:0]  o_M_ByteEn,
  output logic [31:0] o_M_WriteData
);

  localparam int AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam logic [4:0] FULL = 5'(P_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_WAIT, S_ISSUE
  } state_t;

  typedef struct packed {
    logic [15:0] dly;
    logic [13:0] off;
    logic [31:0] data;
  } ent_t;

  ent_t          mem_q [P_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic [31:0]   staging_q, staging_d;
  logic          enable_q, enable_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          m_sel_q, m_sel_d;
  logic          m_wr_q, m_wr_d;
  logic [29:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_data_q, m_data_d;
  state_t        state_q, state_d;

  logic wr, rd, wr_data, wr_cmd, wr_ctrl;
  logic flush, full, empty, pop, push_req, push;
  ent_t head, entry;

  assign wr      = i_SlaveSel & i_AV_Write;
  assign rd      = i_SlaveSel & i_AV_Read;
  assign wr_data = wr & (i_Address == 2'd0);
  assign wr_cmd  = wr & (i_Address == 2'd1);
  assign wr_ctrl = wr & (i_Address == 2'd3);

  assign flush    = wr_ctrl & i_AV_WriteData[1];
  assign full     = (count_q == FULL);
  assign empty    = (count_q == 5'd0);
  assign pop      = (state_q == S_LOAD) & ~flush;
  assign push_req = wr_cmd & ~flush;
  // a full FIFO still takes a push when the head leaves the same cycle
  assign push     = push_req & (~full | pop);

  assign head  = mem_q[rd_ptr_q];
  assign entry = '{dly:  i_AV_WriteData[31:16],
                   off:  i_AV_WriteData[13:0],
                   data: staging_q};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    staging_d = staging_q;
    enable_d  = enable_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    m_sel_d   = 1'b0;
    m_wr_d    = 1'b0;
    m_addr_d  = m_addr_q;
    m_data_d  = m_data_q;
    state_d   = state_q;

    if (wr_data) staging_d = i_AV_WriteData;
    if (wr_ctrl) begin
      enable_d = i_AV_WriteData[0];
      if (i_AV_WriteData[2]) ovf_d = 1'b0;
    end
    if (push_req & full & ~pop) ovf_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + 5'(push) - 5'(pop);

    if (rd)
      rdata_d = (i_Address == 2'd2) ?
        {24'b0, count_q, ovf_q, empty, state_q != S_IDLE} : 32'b0;

    unique case (state_q)
      S_IDLE:
        if (enable_q & ~empty) state_d = S_LOAD;
      S_LOAD: begin
        m_addr_d = P_WSG_BASE | {16'b0, head.off};
        m_data_d = head.data;
        if (head.dly == 16'd0) begin
          state_d = S_ISSUE;
          m_sel_d = 1'b1;
          m_wr_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = head.dly;
        end
      end
      S_WAIT:
        if (i_Tick) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_ISSUE;
            m_sel_d = 1'b1;
            m_wr_d  = 1'b1;
          end
        end
      S_ISSUE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 5'd0;
      state_d  = S_IDLE;
      m_sel_d  = 1'b0;
      m_wr_d   = 1'b0;
    end
  end

  always_ff @(posedge i_Clk)
    if (push) mem_q[wr_ptr_q] <= entry;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 5'd0;
      staging_q <= 32'b0;
      enable_q  <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= 16'd0;
      rdata_q   <= 32'b0;
      m_sel_q   <= 1'b0;
      m_wr_q    <= 1'b0;
      m_addr_q  <= P_WSG_BASE;
      m_data_q  <= 32'b0;
      state_q   <= S_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      staging_q <= staging_d;
      enable_q  <= enable_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      m_sel_q   <= m_sel_d;
      m_wr_q    <= m_wr_d;
      m_addr_q  <= m_addr_d;
      m_data_q  <= m_data_d;
      state_q   <= state_d;
    end
  end

  assign o_AV_ReadData = rdata_q;
  assign o_M_SlaveSel  = m_sel_q;
  assign o_M_Write     = m_wr_q;
  assign o_M_Address   = m_addr_q;
  assign o_M_ByteEn    = 4'hF;
  assign o_M_WriteData = m_data_q;

endmodule

// File: tb/tb_wsg_sequencer.sv
// Directed bench for wsg_sequencer: hand-computed vectors,
// one checking task, write monitor on the falling edge.
module tb_wsg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'b0;
  logic [31:0] rdata;
  logic        tick = 1'b0;
  logic        m_sel, m_wr;
  logic [29:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nw = 0;
  int w_cyc [16];
  logic [29:0] w_addr [16];
  logic [31:0] w_data [16];

  wsg_sequencer dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_SlaveSel     (sel),
    .i_AV_Write     (wr),
    .i_AV_Read      (rd),
    .i_Address      (addr),
    .i_AV_WriteData (wdata),
    .o_AV_ReadData  (rdata),
    .i_Tick         (tick),
    .o_M_SlaveSel   (m_sel),
    .o_M_Write      (m_wr),
    .o_M_Address    (m_addr),
    .o_M_ByteEn     (m_be),
    .o_M_WriteData  (m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (m_sel && m_wr) begin
      if (nw < 16) begin
        w_cyc[nw]  = cyc;
        w_addr[nw] = m_addr;
        w_data[nw] = m_data;
      end
      nw++;
    end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    sel = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovf,
                                     input bit emp, input bit busy);
    logic [4:0] c;
    c = 5'(cnt);
    return {24'b0, c, ovf, emp, busy};
  endfunction

  logic [31:0] r;
  int n0, k_iss;
  logic [3:0] seen;

  initial begin
    // reset values
    idle(2);
    chk("rst_rdata", rdata, 0);
    chk("rst_sel", m_sel, 0);
    chk("rst_wr", m_wr, 0);
    chk("rst_addr", m_addr, 30'h3F008000);
    chk("rst_data", m_data, 0);
    chk("rst_be", m_be, 4'hF);
    rst = 1'b0;
    idle(1);
    bus_rd(2'd2, r);
    chk("rst_status", r, st(0, 0, 1, 0));

    // single delay-0 write, three cycles after enable
    bus_wr(2'd0, 32'hFFFFFFFF);
    bus_wr(2'd1, 32'h00000380);
    n0 = nw;
    bus_wr(2'd3, 32'h1);
    seen = '0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      seen[i] = m_wr;
      if (i == 2) begin
        chk("one_addr", m_addr, 30'h3F008380);
        chk("one_data", m_data, 32'hFFFFFFFF);
        chk("one_sel", m_sel, 1);
      end
    end
    chk("one_shape", seen, 4'b0100);
    chk("one_cnt", nw - n0, 1);
    bus_rd(2'd2, r);
    chk("one_status", r, st(0, 0, 1, 0));

    // back-to-back delay-0 commands
    bus_wr(2'd3, 32'h0);
    bus_wr(2'd0, 32'hAAAA0001);
    bus_wr(2'd1, 32'h00000001);
    bus_wr(2'd0, 32'hBBBB0002);
    bus_wr(2'd1, 32'h00000002);
    n0 = nw;
    bus_wr(2'd3, 32'h1);
    idle(12);
    chk("b2b_cnt", nw - n0, 2);
    chk("b2b_gap", w_cyc[n0+1] - w_cyc[n0], 3);
    chk("b2b_d0", w_data[n0], 32'hAAAA0001);
    chk("b2b_a1", w_addr[n0+1], 30'h3F008002);
    chk("b2b_d1", w_data[n0+1], 32'hBBBB0002);

    // delay 3, tick every 10 cycles
    bus_wr(2'd3, 32'h0);
    bus_wr(2'd0, 32'h12345678);
    bus_wr(2'd1, 32'h00030010);
    n0 = nw;
    bus_wr(2'd3, 32'h1);
    k_iss = 0;
    for (int k = 1; k <= 40; k++) begin
      tick = (k % 10 == 5);
      @(posedge clk); #1;
      if (m_wr && k_iss == 0) begin
        k_iss = k;
        chk("dly_addr", m_addr, 30'h3F008010);
        chk("dly_data", m_data, 32'h12345678);
      end
    end
    tick = 1'b0;
    chk("dly_when", k_iss, 25);
    chk("dly_cnt", nw - n0, 1);

    // overflow with enable low
    bus_wr(2'd3, 32'h0);
    for (int i = 0; i < 9; i++) bus_wr(2'd1, 32'(i));
    bus_rd(2'd2, r);
    chk("ovf_status", r, st(8, 1, 0, 0));
    bus_wr(2'd3, 32'h4);
    bus_rd(2'd2, r);
    chk("ovf_clear", r, st(8, 0, 0, 0));

    // full FIFO: push lands on the LOAD pop
    bus_wr(2'd3, 32'h1);
    idle(1);
    bus_wr(2'd1, 32'h00000055);
    bus_wr(2'd3, 32'h0);
    idle(2);
    bus_rd(2'd2, r);
    chk("full_pp", r, st(8, 0, 0, 0));

    // flush during WAIT
    bus_wr(2'd3, 32'h2);
    bus_wr(2'd0, 32'h0BADF00D);
    bus_wr(2'd1, 32'h00640004);
    bus_wr(2'd3, 32'h1);
    idle(4);
    bus_rd(2'd2, r);
    chk("fl_busy", r, st(0, 0, 1, 1));
    n0 = nw;
    bus_wr(2'd3, 32'h3);
    tick = 1'b1;
    idle(110);
    tick = 1'b0;
    chk("fl_nowr", nw - n0, 0);
    bus_rd(2'd2, r);
    chk("fl_status", r, st(0, 0, 1, 0));

    // async reset mid-WAIT
    bus_wr(2'd3, 32'h0);
    bus_wr(2'd0, 32'hDEADBEEF);
    bus_wr(2'd1, 32'h00050123);
    bus_wr(2'd3, 32'h1);
    idle(3);
    bus_rd(2'd2, r);
    chk("ar_busy", r, st(0, 0, 1, 1));
    chk("ar_pre_data", m_data, 32'hDEADBEEF);
    n0 = nw;
    rst = 1'b1;
    #2;
    chk("ar_rdata", rdata, 0);
    chk("ar_sel", m_sel, 0);
    chk("ar_wr", m_wr, 0);
    chk("ar_addr", m_addr, 30'h3F008000);
    chk("ar_data", m_data, 0);
    chk("ar_be", m_be, 4'hF);
    @(posedge clk); #1;
    rst = 1'b0;
    tick = 1'b1;
    idle(20);
    tick = 1'b0;
    chk("ar_nowr", nw - n0, 0);
    bus_rd(2'd2, r);
    chk("ar_status", r, st(0, 0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wsg_sequencer.md
WSG_SEQUENCER -- requirements
Module: wsg_sequencer

Interface
REQ-001 SHALL have parameter P_WSG_BASE, default 30'h3F008000, 30-bit word address of the wsg register window.
REQ-002 SHALL have parameter P_DEPTH, default 8, command FIFO depth (power of 2, 2..16).
REQ-003 SHALL have port i_Clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_Reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_SlaveSel  in  1  CPU slave select.
REQ-006 SHALL have port i_AV_Write  in  1  CPU write strobe, valid only with i_SlaveSel.
REQ-007 SHALL have port i_AV_Read  in  1  CPU read strobe, valid only with i_SlaveSel.
REQ-008 SHALL have port i_Address  in  2  register select: 0 DATA, 1 CMD, 2 STATUS, 3 CTRL.
REQ-009 SHALL have port i_AV_WriteData  in  32  CPU write data.
REQ-010 SHALL have port o_AV_ReadData  out  32  CPU read data, registered.
REQ-011 SHALL have port i_Tick  in  1  one-cycle time-base strobe.
REQ-012 SHALL have port o_M_SlaveSel  out  1  select toward wsg.
REQ-013 SHALL have port o_M_Write  out  1  write strobe toward wsg.
REQ-014 SHALL have port o_M_Address  out  30  P_WSG_BASE OR {16'b0, offset[13:0]}.
REQ-015 SHALL have port o_M_ByteEn  out  4  constant 4'hF.
REQ-016 SHALL have port o_M_WriteData  out  32  command data toward wsg.

Function
REQ-017 SHALL latch i_AV_WriteData into a staging register on write to DATA.
REQ-018 SHALL, on write to CMD, push entry {delay=WriteData[31:16], offset=WriteData[13:0], data=staging} into the FIFO.
REQ-019 SHALL drop a CMD push when FIFO full and no pop occurs that cycle, setting sticky overflow flag.
REQ-020 SHALL accept push and pop in the same cycle when full, count unchanged.
REQ-021 SHALL, on CTRL write, set enable=bit0; bit1=1 flushes; bit2=1 clears overflow.
REQ-022 SHALL, on flush, empty FIFO and force FSM to IDLE with no wsg write that cycle; flush overrides a simultaneous push.
REQ-023 SHALL return on STATUS read {24'b0, count[4:0], overflow, empty, busy}, busy=FSM not IDLE; other registers read 0.
REQ-024 SHALL present o_AV_ReadData one cycle after the read strobe; hold value otherwise.
REQ-025 SHALL implement FSM IDLE, LOAD, WAIT, ISSUE.
REQ-026 IDLE->LOAD SHALL occur when enable=1 and FIFO not empty; LOAD pops the head into working registers.
REQ-027 LOAD SHALL go to ISSUE if delay=0, else to WAIT with counter=delay.
REQ-028 WAIT SHALL decrement counter on each i_Tick and go to ISSUE on the cycle counter becomes 0.
REQ-029 ISSUE SHALL assert o_M_SlaveSel and o_M_Write for exactly one cycle with address and data of the working entry, then return to IDLE.
REQ-030 SHALL keep o_M_SlaveSel/o_M_Write low outside ISSUE; clearing enable only blocks new pops, a command in WAIT/ISSUE completes.
REQ-031 Back-to-back delay-0 commands SHALL issue every 3 cycles (IDLE, LOAD, ISSUE).

Reset
REQ-032 i_Reset high SHALL immediately force: FSM IDLE, FIFO empty, enable=0, overflow=0, staging=0, counter=0, o_AV_ReadData=0, o_M_SlaveSel=0, o_M_Write=0, o_M_Address=P_WSG_BASE, o_M_WriteData=0, o_M_ByteEn=4'hF.
REQ-033 Reset during WAIT or ISSUE SHALL abort the command with no wsg write.

Verification
REQ-034 DATA<=FFFFFFFF, CMD<=00000380, CTRL<=1 -> one wsg write, address 30'h3F008380, data FFFFFFFF, 1 cycle wide, three cycles after enable.
REQ-035 CMD delay=3, i_Tick every 10 cycles -> write issues on cycle of 3rd tick after LOAD, not before.
REQ-036 Enable=0, 9 pushes (P_DEPTH=8) -> STATUS reads count=8, overflow=1, empty=0; CTRL<=4 clears overflow.
REQ-037 Command in WAIT, CTRL<=2 -> no wsg write, STATUS reads busy=0, empty=1, count=0.
REQ-038 i_Reset asserted mid-WAIT between clock edges -> outputs reach reset values before next edge, no write after release.
REQ-039 FIFO full, push coincident with LOAD pop -> push accepted, count stays 8, overflow stays 0.
